// File: rtl/cnn_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : cnn_uart_tx
// Description : Transmit end of the CNN host link. Buffers result bytes in a
//               small circular FIFO and serializes them as 8N1 UART frames,
//               LSB first, back to back with no idle gap when data is queued.
// Revision    : 1.0 - initial release
// ============================================================================
module cnn_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       TX,
    output logic       tx_done,
    output logic       bsy,
    output logic       full,
    output logic       ovf
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;

    // Serializer state
    state_t        state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_bit_end;

    assign w_empty   = (count_q == '0);
    assign w_full    = (count_q == (AW+1)'(FIFO_DEPTH));
    assign w_bit_end = (baud_q == CNT_W'(CLKS_PER_BIT - 1));
    // A full FIFO still accepts a byte when the head leaves on the same edge.
    assign w_push    = trmt && (!w_full || w_pop);

    // Serializer next-state: pops the FIFO head when a frame may start.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        w_pop   = 1'b0;
        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (!w_empty) begin
                    w_pop   = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    state_d = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    baud_d = '0;
                    // Chain straight into the next start bit when data waits.
                    if (!w_empty) begin
                        w_pop   = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Line level for the next cycle, derived from the next state so TX is a flop.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    // FIFO pointer, occupancy and overflow next-state.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q | (trmt & ~w_push);
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO data storage; contents need no reset since occupancy guards reads.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= tx_data;
        end
    end

    // State registers with asynchronous reset so TX idles high immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    assign TX      = tx_q;
    assign tx_done = (state_q == S_STOP) && w_bit_end;
    assign bsy     = (state_q != S_IDLE) || !w_empty;
    assign full    = w_full;
    assign ovf     = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_cnn_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_cnn_uart_tx
// Description : Directed self-checking bench for cnn_uart_tx with
//               CLKS_PER_BIT=4 and FIFO_DEPTH=4 (frame = 40 cycles).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cnn_uart_tx;

    localparam int CLKS = 4;
    localparam int DEPTH = 4;

    logic       clk;
    logic       rst;
    logic       trmt;
    logic [7:0] tx_data;
    logic       TX;
    logic       tx_done;
    logic       bsy;
    logic       full;
    logic       ovf;

    int checks;
    int failures;

    cnn_uart_tx #(
        .CLKS_PER_BIT(CLKS),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .trmt   (trmt),
        .tx_data(tx_data),
        .TX     (TX),
        .tx_done(tx_done),
        .bsy    (bsy),
        .full   (full),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check frame cycles first..last (0 = first start-bit cycle, 39 = last stop cycle).
    task automatic frame(input logic [7:0] b, input int first, input int last);
        logic eb;
        for (int i = first; i <= last; i++) begin
            if (i < 4)       eb = 1'b0;
            else if (i < 36) eb = b[(i - 4) / 4];
            else             eb = 1'b1;
            chk($sformatf("frame_%02h_c%0d_tx_done", b, i), {30'd0, TX, tx_done},
                {30'd0, eb, (i == 39)});
            chk($sformatf("frame_%02h_c%0d_bsy", b, i), {31'd0, bsy}, 32'd1);
            tick();
        end
    endtask

    task automatic push(input logic [7:0] b);
        trmt    = 1'b1;
        tx_data = b;
        tick();
        trmt    = 1'b0;
    endtask

    initial begin
        int viol;
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        trmt     = 1'b0;
        tx_data  = 8'h00;

        // Reset state
        tick();
        tick();
        chk("rst_tx", {31'd0, TX}, 32'd1);
        chk("rst_flags", {28'd0, tx_done, bsy, full, ovf}, 32'd0);
        rst = 1'b0;
        tick();

        // Single byte 0xA5: start bit at cycle 2, done at cycle 41, bsy low at 42
        push(8'hA5);
        chk("single_c1_tx", {31'd0, TX}, 32'd1);
        chk("single_c1_bsy", {31'd0, bsy}, 32'd1);
        tick();
        frame(8'hA5, 0, 39);
        chk("single_end_bsy", {31'd0, bsy}, 32'd0);
        chk("single_end_tx", {31'd0, TX}, 32'd1);

        // Back-to-back frames with no idle gap
        push(8'h00);
        trmt = 1'b1; tx_data = 8'hFF; tick();
        chk("b2b_c2_tx", {31'd0, TX}, 32'd0);
        trmt = 1'b1; tx_data = 8'h3C; tick();
        trmt = 1'b0;
        frame(8'h00, 1, 39);
        frame(8'hFF, 0, 39);
        frame(8'h3C, 0, 39);
        chk("b2b_end_bsy", {31'd0, bsy}, 32'd0);

        // Overflow while a frame is in flight
        push(8'h77);
        tick();
        trmt = 1'b1;
        tx_data = 8'h01; tick();
        tx_data = 8'h02; tick();
        tx_data = 8'h03; tick();
        chk("ovf_full_before4", {31'd0, full}, 32'd0);
        tx_data = 8'h04; tick();
        chk("ovf_full_after4", {31'd0, full}, 32'd1);
        chk("ovf_clear_after4", {31'd0, ovf}, 32'd0);
        tx_data = 8'h05; tick();
        trmt = 1'b0;
        chk("ovf_set", {31'd0, ovf}, 32'd1);
        chk("ovf_full_after5", {31'd0, full}, 32'd1);
        frame(8'h77, 5, 39);
        frame(8'h01, 0, 39);
        frame(8'h02, 0, 39);
        frame(8'h03, 0, 39);
        frame(8'h04, 0, 39);
        chk("ovf_sticky", {31'd0, ovf}, 32'd1);
        chk("ovf_end_bsy", {31'd0, bsy}, 32'd0);

        // Push and pop on the same edge while full
        rst = 1'b1; tick(); rst = 1'b0;
        chk("pp_ovf_cleared", {31'd0, ovf}, 32'd0);
        push(8'h10);
        trmt = 1'b1;
        tx_data = 8'h11; tick();
        tx_data = 8'h12; tick();
        tx_data = 8'h13; tick();
        tx_data = 8'h14; tick();
        trmt = 1'b0;
        chk("pp_full", {31'd0, full}, 32'd1);
        frame(8'h10, 3, 38);
        chk("pp_last_stop", {30'd0, TX, tx_done}, {30'd0, 1'b1, 1'b1});
        trmt = 1'b1; tx_data = 8'h15; tick();
        trmt = 1'b0;
        chk("pp_full_after", {31'd0, full}, 32'd1);
        chk("pp_ovf_after", {31'd0, ovf}, 32'd0);
        frame(8'h11, 0, 39);
        frame(8'h12, 0, 39);
        frame(8'h13, 0, 39);
        frame(8'h14, 0, 39);
        frame(8'h15, 0, 39);
        chk("pp_end_bsy", {31'd0, bsy}, 32'd0);

        // Reset mid-frame during data bit 3 of 0x55 (bit value 0)
        push(8'h55);
        tick();
        frame(8'h55, 0, 17);
        chk("mid_pre_tx", {31'd0, TX}, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_async_tx", {31'd0, TX}, 32'd1);
        chk("mid_async_flags", {28'd0, tx_done, bsy, full, ovf}, 32'd0);
        tick();
        chk("mid_held_tx", {31'd0, TX}, 32'd1);
        chk("mid_held_done", {31'd0, tx_done}, 32'd0);
        rst = 1'b0;
        tick();
        push(8'h81);
        tick();
        frame(8'h81, 0, 39);
        chk("mid_end_bsy", {31'd0, bsy}, 32'd0);

        // Idle line for 1000 cycles after reset
        rst = 1'b1; tick(); rst = 1'b0;
        viol = 0;
        for (int i = 0; i < 1000; i++) begin
            if (TX !== 1'b1 || bsy !== 1'b0 || tx_done !== 1'b0) viol++;
            tick();
        end
        chk("idle_violations", viol, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
